eep_responder: RTL
==================

// Module: eep_responder
// PURPOSE
//  EEPROM-side responder to the digital core's 2-bit-address, 14-bit-data EEPROM port.
//  Holds 4 x 14-bit nonvolatile words (Xset, P, I, D coefficients).
//  Serves reads with 1-cycle latency. Commits writes only after the core holds chrg_pmp_en high for the programming time.
//  Sits opposite the core in the top level and in the core's bench.
// PARAMETERS
//  DW          14     data width
//  AW          2      address width; depth = 2**AW
//  CP_CYCLES   1024   consecutive chrg_pmp_en-high cycles required to commit a write
//  TO_CYCLES   4096   max cycles from write request to first chrg_pmp_en high; exceeding it aborts the write
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  eep_cs_n     in   1    chip select, active-low, sampled each clk
//  eep_r_w_n    in   1    1 = read, 0 = write (qualified by eep_cs_n = 0)
//  eep_addr     in   AW   word address
//  eep_wr_data  in   DW   write data (driven from the core's dst bus)
//  chrg_pmp_en  in   1    charge pump enable from the core
//  eep_rd_data  out  DW   read data, registered
//  eep_busy     out  1    write in progress; accesses are ignored while high
//  eep_wr_err   out  1    sticky; set on an aborted write, cleared by the next accepted access
// BEHAVIOUR
//  Reset values: eep_rd_data = 0, eep_busy = 0, eep_wr_err = 0, state = IDLE, counters = 0.
//  States: IDLE, WR_WAIT, WR_PROG.
//  IDLE, cs_n = 0, r_w_n = 1: eep_rd_data <= mem[addr] at the next edge; valid 1 cycle after the request.
//   eep_rd_data holds its value until the next read.
//  IDLE, cs_n = 0, r_w_n = 0: latch addr and data; eep_busy <= 1; go to WR_WAIT.
//  WR_WAIT:
//   - chrg_pmp_en = 1: go to WR_PROG with cp_cnt = 1.
//   - TO_CYCLES elapsed with chrg_pmp_en still low: eep_wr_err <= 1; go to IDLE; memory unchanged.
//  WR_PROG:
//   - chrg_pmp_en = 1: cp_cnt++. When cp_cnt reaches CP_CYCLES, mem[addr] <= data, eep_busy <= 0, go to IDLE.
//   - chrg_pmp_en drops before CP_CYCLES: abort, eep_wr_err <= 1, memory unchanged, go to IDLE.
//  While eep_busy = 1, cs_n accesses are ignored: eep_rd_data is not updated and latched addr/data do not change.
//  chrg_pmp_en high in IDLE has no effect.
//  Read and write on the same word:
//   - a read issued in the commit cycle is not serviced (eep_busy is still 1);
//   - the first read after eep_busy falls returns the new data.
//  Counters are saturating, sized $clog2(max(CP_CYCLES, TO_CYCLES)) + 1; no wrap-around.
//  rst mid-write: the write is discarded, memory is unchanged, and eep_busy and eep_wr_err go to 0.
// CONFIGURATION
//  EEP_PRELOAD_EN defined:
//   - rst loads mem[0..3] from parameters INIT0..INIT3 (each default 14'h0000).
//   - Gives the core known coefficients at power-up.
//  EEP_PRELOAD_EN undefined:
//   - rst does not touch mem (true nonvolatile behaviour); contents persist across resets.
//   - Power-up contents are X until written.
// STRUCTURE
//  Package eep_resp_pkg holds:
//   - eep_state_t enum {IDLE, WR_WAIT, WR_PROG};
//   - localparams EEP_DW = 14, EEP_AW = 2;
//   - address names ADDR_XSET = 0, ADDR_P = 1, ADDR_I = 2, ADDR_D = 3.
//  Sub-module eep_cp_timer: saturating counter with clr, inc, and a terminal-count compare against CP_CYCLES/TO_CYCLES.
//  Top holds the FSM, the memory array and the output registers.
// TESTING (bench uses CP_CYCLES = 8, TO_CYCLES = 16)
//  1. Write addr 2 = 14'h1ABC with chrg_pmp_en high 8 cycles, then read addr 2
//     -> eep_busy low after cycle 8; eep_rd_data = 14'h1ABC one cycle after the read.
//  2. Write addr 1 = 14'h0FFF; drop chrg_pmp_en after 5 cycles
//     -> eep_wr_err = 1; read addr 1 returns the old value.
//  3. Write request with chrg_pmp_en never raised
//     -> after 16 cycles eep_wr_err = 1 and eep_busy = 0.
//  4. Read addr 0 while eep_busy = 1 -> eep_rd_data unchanged; next legal read addr 0 returns stored data.
//  5. Assert rst during WR_PROG cycle 4
//     -> eep_busy = 0, eep_wr_err = 0, target word unchanged (preload value with EEP_PRELOAD_EN).
//  6. Back-to-back reads addr 0, 1, 2, 3 on consecutive cycles -> four data words on consecutive cycles, 1-cycle latency.

Source files
------------

// File: rtl/eep_resp_pkg.sv
// Shared types and constants for the EEPROM responder.
package eep_resp_pkg;

    localparam int unsigned EEP_DW = 14;
    localparam int unsigned EEP_AW = 2;

    localparam logic [EEP_AW-1:0] ADDR_XSET = 2'd0;
    localparam logic [EEP_AW-1:0] ADDR_P    = 2'd1;
    localparam logic [EEP_AW-1:0] ADDR_I    = 2'd2;
    localparam logic [EEP_AW-1:0] ADDR_D    = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        WR_PROG
    } eep_state_t;

    // Counter width that holds the larger of the two terminal counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/eep_cp_timer.sv
// Saturating cycle counter with terminal-count flags for programming time and request timeout.
module eep_cp_timer
    import eep_resp_pkg::*;
#(
    parameter int unsigned CP_CYCLES = 1024,
    parameter int unsigned TO_CYCLES = 4096,
    parameter int unsigned CW        = cnt_width(CP_CYCLES, TO_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic cp_hit,
    output logic to_hit
);

    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;

    // clr together with inc restarts the count at 1 (the current cycle counts).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CW'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Flags report whether counting the current cycle reaches the terminal count.
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign cp_hit  = cnt_inc >= (CW+1)'(CP_CYCLES);
    assign to_hit  = cnt_inc >= (CW+1)'(TO_CYCLES);

endmodule

// File: rtl/eep_responder.sv
// EEPROM-side responder: 4 x 14-bit words, 1-cycle reads, writes committed after charge-pump time.
// Define EEP_PRELOAD_EN to load the words from INIT0..INIT3 on reset.
module eep_responder
    import eep_resp_pkg::*;
#(
    parameter int unsigned DW        = EEP_DW,
    parameter int unsigned AW        = EEP_AW,
    parameter int unsigned CP_CYCLES = 1024,
    parameter int unsigned TO_CYCLES = 4096
`ifdef EEP_PRELOAD_EN
    ,
    parameter logic [DW-1:0] INIT0 = '0,
    parameter logic [DW-1:0] INIT1 = '0,
    parameter logic [DW-1:0] INIT2 = '0,
    parameter logic [DW-1:0] INIT3 = '0
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eep_cs_n,
    input  logic          eep_r_w_n,
    input  logic [AW-1:0] eep_addr,
    input  logic [DW-1:0] eep_wr_data,
    input  logic          chrg_pmp_en,
    output logic [DW-1:0] eep_rd_data,
    output logic          eep_busy,
    output logic          eep_wr_err
);

    localparam bit CommitOnFirst = (CP_CYCLES <= 1);

    eep_state_t    state;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          tmr_clr;
    logic          tmr_inc;
    logic          cp_hit;
    logic          to_hit;

    // Timer counts low cycles in WR_WAIT, then restarts at 1 on the first charge-pump cycle.
    always_comb begin
        tmr_clr = (state == IDLE) || ((state == WR_WAIT) && chrg_pmp_en);
        tmr_inc = (state != IDLE);
    end

    eep_cp_timer #(
        .CP_CYCLES (CP_CYCLES),
        .TO_CYCLES (TO_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .cp_hit (cp_hit),
        .to_hit (to_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            eep_rd_data <= '0;
            eep_busy    <= 1'b0;
            eep_wr_err  <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
`ifdef EEP_PRELOAD_EN
            mem[ADDR_XSET] <= INIT0;
            mem[ADDR_P]    <= INIT1;
            mem[ADDR_I]    <= INIT2;
            mem[ADDR_D]    <= INIT3;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (!eep_cs_n) begin
                        eep_wr_err <= 1'b0;
                        if (eep_r_w_n) begin
                            eep_rd_data <= mem[eep_addr];
                        end else begin
                            wr_addr  <= eep_addr;
                            wr_data  <= eep_wr_data;
                            eep_busy <= 1'b1;
                            state    <= WR_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (chrg_pmp_en) begin
                        if (CommitOnFirst) begin
                            mem[wr_addr] <= wr_data;
                            eep_busy     <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            state <= WR_PROG;
                        end
                    end else if (to_hit) begin
                        eep_wr_err <= 1'b1;
                        eep_busy   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WR_PROG: begin
                    if (!chrg_pmp_en) begin
                        eep_wr_err <= 1'b1;
                        eep_busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (cp_hit) begin
                        mem[wr_addr] <= wr_data;
                        eep_busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    eep_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
